// File: rtl/box_fetch_unit_if.sv
`default_nettype none
//============================================================================
// Module : box_fetch_unit_if
// Object-memory read port plus unpacked-box valid/ready stream of the fetch unit.
// Rev    : 1.0
//============================================================================
interface box_fetch_unit_if #(
    parameter int ADDR_W  = 6,
    parameter int COORD_W = 8
);
    logic [ADDR_W-1:0]    mem_addr;
    logic                 mem_rd_en;
    logic [4*COORD_W-1:0] mem_rdata;
    logic                 box_valid;
    logic                 box_ready;
    logic [COORD_W-1:0]   box_xmin;
    logic [COORD_W-1:0]   box_xmax;
    logic [COORD_W-1:0]   box_ymin;
    logic [COORD_W-1:0]   box_ymax;
    logic [31:0]          box_index;

    modport master (
        output mem_addr, mem_rd_en,
        input  mem_rdata,
        output box_valid,
        input  box_ready,
        output box_xmin, box_xmax, box_ymin, box_ymax, box_index
    );

    modport slave (
        input  mem_addr, mem_rd_en,
        output mem_rdata,
        input  box_valid,
        output box_ready,
        input  box_xmin, box_xmax, box_ymin, box_ymax, box_index
    );
endinterface
`default_nettype wire

// File: rtl/box_fetch_unit.sv
`default_nettype none
//============================================================================
// Module : box_fetch_unit
// Reads one packed box per controller address, unpacks it and hands it over
// on valid/ready. Macro BOX_FETCH_COUNT_EN adds box_count / count_mismatch.
// Rev    : 1.0
//============================================================================
module box_fetch_unit #(
    parameter int ADDR_W      = 6,
    parameter int MEM_LATENCY = 1,
    parameter int COORD_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    box_fetch_unit_if.master bus,
    input  logic [31:0]      address,
    input  logic             output_enable,
    input  logic             end_of_memory,
    output logic             fetch_data_ready,
    output logic             done
`ifdef BOX_FETCH_COUNT_EN
    ,
    output logic [31:0]      box_count,
    output logic             count_mismatch
`endif
);

    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_LATENCY - 1);

    localparam logic [2:0] S_PRIME   = 3'd0;
    localparam logic [2:0] S_SETTLE  = 3'd1;
    localparam logic [2:0] S_ISSUE   = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_PRESENT = 3'd4;
    localparam logic [2:0] S_ADVANCE = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    logic [2:0]         r_state;
    logic [2:0]         w_state_next;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic               r_fdr;
    logic               r_rd_en;
    logic               r_valid;
    logic               r_done;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [31:0]        r_index;
    logic [COORD_W-1:0] r_xmin;
    logic [COORD_W-1:0] r_xmax;
    logic [COORD_W-1:0] r_ymin;
    logic [COORD_W-1:0] r_ymax;

    logic w_handshake;
    logic w_last_wait;
    logic w_fdr_next;
    logic w_rd_en_next;
    logic w_valid_next;
    logic w_done_next;
    logic w_issue;
    logic w_capture;

    assign w_handshake = r_valid & bus.box_ready;
    assign w_last_wait = (r_wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_PRIME;
        end else begin
            r_state <= w_state_next;
        end
    end

    // PRIME holds until its registered pulse has actually been driven, so the
    // reset cycle itself (outputs forced low) never counts as the pulse.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_PRIME: begin
                if (r_fdr) w_state_next = S_SETTLE;
            end
            S_SETTLE: begin
                if (end_of_memory)      w_state_next = S_DONE;
                else if (output_enable) w_state_next = S_ISSUE;
            end
            S_ISSUE:   w_state_next = S_WAIT;
            S_WAIT: begin
                if (w_last_wait) w_state_next = S_PRESENT;
            end
            S_PRESENT: begin
                if (w_handshake) w_state_next = S_ADVANCE;
            end
            S_ADVANCE: w_state_next = S_SETTLE;
            S_DONE:    w_state_next = S_DONE;
            default:   w_state_next = S_PRIME;
        endcase
    end

    // Outputs are decoded from the next state and registered, so each one is
    // high exactly during the cycle its state is current and glitch-free.
    always_comb begin
        w_fdr_next   = (w_state_next == S_PRIME) || (w_state_next == S_ADVANCE);
        w_rd_en_next = (w_state_next == S_ISSUE);
        w_valid_next = (w_state_next == S_PRESENT);
        w_done_next  = (w_state_next == S_DONE);
        w_issue      = (w_state_next == S_ISSUE);
        w_capture    = (r_state == S_WAIT) && w_last_wait;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fdr      <= 1'b0;
            r_rd_en    <= 1'b0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_wait_cnt <= '0;
            r_mem_addr <= '0;
            r_index    <= '0;
            r_xmin     <= '0;
            r_xmax     <= '0;
            r_ymin     <= '0;
            r_ymax     <= '0;
        end else begin
            r_fdr   <= w_fdr_next;
            r_rd_en <= w_rd_en_next;
            r_valid <= w_valid_next;
            r_done  <= w_done_next;
            if (w_issue) begin
                r_mem_addr <= address[ADDR_W-1:0];
                r_index    <= address;
            end
            if (r_state == S_ISSUE) begin
                r_wait_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end
            if (w_capture) begin
                r_xmin <= bus.mem_rdata[COORD_W-1:0];
                r_xmax <= bus.mem_rdata[2*COORD_W-1:COORD_W];
                r_ymin <= bus.mem_rdata[3*COORD_W-1:2*COORD_W];
                r_ymax <= bus.mem_rdata[4*COORD_W-1:3*COORD_W];
            end
        end
    end

    assign fetch_data_ready = r_fdr;
    assign done             = r_done;
    assign bus.mem_addr     = r_mem_addr;
    assign bus.mem_rd_en    = r_rd_en;
    assign bus.box_valid    = r_valid;
    assign bus.box_xmin     = r_xmin;
    assign bus.box_xmax     = r_xmax;
    assign bus.box_ymin     = r_ymin;
    assign bus.box_ymax     = r_ymax;
    assign bus.box_index    = r_index;

`ifdef BOX_FETCH_COUNT_EN
    logic [31:0] r_box_count;
    logic        r_count_mismatch;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_box_count      <= '0;
            r_count_mismatch <= 1'b0;
        end else begin
            if (w_handshake && (r_box_count != 32'hFFFF_FFFF)) begin
                r_box_count <= r_box_count + 32'd1;
            end
            if ((r_state == S_DONE) && (r_box_count != r_index + 32'd1)) begin
                r_count_mismatch <= 1'b1;
            end
        end
    end

    assign box_count      = r_box_count;
    assign count_mismatch = r_count_mismatch;
`endif

endmodule
`default_nettype wire

// File: tb/tb_box_fetch_unit.sv
`default_nettype none
//============================================================================
// Module : tb_box_fetch_unit
// Two fetch units (latency 1 and 3) against a controller model and scoreboard.
// Rev    : 1.0
//============================================================================
module tb_box_fetch_unit;

    typedef struct { logic [31:0] idx; logic [31:0] flds; int cyc; } hs_t;
    typedef struct { logic [5:0] addr; int cyc; } iss_t;
    typedef struct { int addr; logic [31:0] word; logic [7:0] xmin, xmax, ymin, ymax; } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ready;
    logic [31:0] base;
    int unsigned thr;
    logic [31:0] mem [64];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;

    logic        fdr_v  [2];
    logic        done_v [2];
    logic        rd_v   [2];
    logic        val_v  [2];
    logic [5:0]  maddr_v[2];
    logic [31:0] flds_v [2];
    logic [31:0] idx_v  [2];
`ifdef BOX_FETCH_COUNT_EN
    logic [31:0] cnt_v  [2];
    logic        mism_v [2];
`endif

    hs_t  hs_q [2][$];
    iss_t iss_q[2][$];
    int   fdr_q[2][$];
    logic        prev_fdr  [2];
    logic        prev_stall[2];
    logic [31:0] prev_flds [2];
    logic [31:0] prev_idx  [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_env
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [31:0] ctl_off;
        logic        ctl_oe;
        logic        ctl_eom;
        logic [31:0] p0, p1, p2;
        logic        fdr;
        logic        dn;
`ifdef BOX_FETCH_COUNT_EN
        logic [31:0] cnt;
        logic        mism;
        assign cnt_v[g]  = cnt;
        assign mism_v[g] = mism;
`endif

        box_fetch_unit_if #(.ADDR_W(6), .COORD_W(8)) bus ();

        box_fetch_unit #(.ADDR_W(6), .MEM_LATENCY(LAT), .COORD_W(8)) dut (
            .clk              (clk),
            .rst              (rst),
            .bus              (bus),
            .address          (base + ctl_off),
            .output_enable    (ctl_oe),
            .end_of_memory    (ctl_eom),
            .fetch_data_ready (fdr),
            .done             (dn)
`ifdef BOX_FETCH_COUNT_EN
            ,
            .box_count        (cnt),
            .count_mismatch   (mism)
`endif
        );

        // Controller: first pulse primes, later pulses advance; after thr, flag end.
        always @(posedge clk or negedge rst) begin
            if (!rst) begin
                ctl_off <= 32'd0;
                ctl_oe  <= 1'b0;
                ctl_eom <= 1'b0;
            end else if (fdr) begin
                if (!ctl_oe)             ctl_oe  <= 1'b1;
                else if (ctl_off == thr) ctl_eom <= 1'b1;
                else                     ctl_off <= ctl_off + 32'd1;
            end
        end

        always @(posedge clk) begin
            p0 <= bus.mem_rd_en ? mem[bus.mem_addr] : 32'hDEAD_BEEF;
            p1 <= p0;
            p2 <= p1;
        end

        assign bus.mem_rdata = (LAT == 1) ? p0 : p2;
        assign bus.box_ready = ready;
        assign fdr_v[g]   = fdr;
        assign done_v[g]  = dn;
        assign rd_v[g]    = bus.mem_rd_en;
        assign val_v[g]   = bus.box_valid;
        assign maddr_v[g] = bus.mem_addr;
        assign flds_v[g]  = {bus.box_ymax, bus.box_ymin, bus.box_xmax, bus.box_xmin};
        assign idx_v[g]   = bus.box_index;
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_fields(input logic [31:0] w);
        int unsigned v;
        v = w;
        return {8'(v / 32'h0100_0000), 8'((v / 32'h0001_0000) % 256),
                8'((v / 256) % 256), 8'(v % 256)};
    endfunction

    always @(negedge clk) begin
        for (int e = 0; e < 2; e++) begin
            if (!rst) begin
                prev_fdr[e]   <= 1'b0;
                prev_stall[e] <= 1'b0;
            end else begin
                if (fdr_v[e]) begin
                    chk("fdr_back_to_back", prev_fdr[e], 1'b0);
                    fdr_q[e].push_back(cyc);
                end
                if (rd_v[e]) begin
                    chk("rd_en_in_done", done_v[e], 1'b0);
                    iss_q[e].push_back('{maddr_v[e], cyc});
                end
                if (prev_stall[e])
                    chk("stall_hold", {val_v[e], flds_v[e], idx_v[e]}, {1'b1, prev_flds[e], prev_idx[e]});
                if (val_v[e] && ready)
                    hs_q[e].push_back('{idx_v[e], flds_v[e], cyc});
                prev_fdr[e]   <= fdr_v[e];
                prev_stall[e] <= val_v[e] && !ready;
                prev_flds[e]  <= flds_v[e];
                prev_idx[e]   <= idx_v[e];
            end
        end
    end

    task automatic check_zero(input string nm);
        for (int e = 0; e < 2; e++) begin
            chk(nm, {fdr_v[e], done_v[e], rd_v[e], val_v[e], maddr_v[e], flds_v[e], idx_v[e]}, 128'd0);
`ifdef BOX_FETCH_COUNT_EN
            chk(nm, {cnt_v[e], mism_v[e]}, 128'd0);
`endif
        end
    endtask

    task automatic clear_logs();
        for (int e = 0; e < 2; e++) begin
            hs_q[e].delete();
            iss_q[e].delete();
            fdr_q[e].delete();
        end
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_state");
        clear_logs();
        rst = 1'b1;
    endtask

    task automatic run_until_done(input bit rnd, input int budget);
        int n = 0;
        while (!(done_v[0] && done_v[1]) && n < budget) begin
            @(posedge clk); #1;
            if (rnd) ready = 1'($urandom_range(0, 1));
            n++;
        end
        chk("run_completes", n < budget, 1'b1);
        ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
    endtask

    // Expected record stream: addresses base..base+thr, each word from mem[low bits].
    task automatic check_run(input int e, input int nrec);
        int          np;
        logic [31:0] idx;
        chk("handshake_count", hs_q[e].size(), nrec);
        chk("issue_count", iss_q[e].size(), nrec);
        chk("pulse_count", fdr_q[e].size(), nrec + 1);
        chk("done_flag", done_v[e], 1'b1);
        if (iss_q[e].size() > 0) begin
            np = 0;
            for (int k = 0; k < fdr_q[e].size(); k++)
                if (fdr_q[e][k] < iss_q[e][0].cyc) np++;
            chk("prime_pulses", np, 1);
        end
        for (int i = 0; i < nrec && i < hs_q[e].size() && i < iss_q[e].size(); i++) begin
            idx = base + 32'(i);
            chk("box_index", hs_q[e][i].idx, idx);
            chk("box_fields", hs_q[e][i].flds, exp_fields(mem[idx[5:0]]));
            chk("mem_addr", iss_q[e][i].addr, idx[5:0]);
        end
    endtask

    initial begin
        vec_t        tv[4];
        int          n;
        int          lat;
        logic [31:0] f;
        logic [31:0] snap_f, snap_i;

        tv[0] = '{3, 32'h4030_2010, 8'h10, 8'h20, 8'h30, 8'h40};
        tv[1] = '{4, 32'hFF00_FF00, 8'h00, 8'hFF, 8'h00, 8'hFF};
        tv[2] = '{5, 32'h0102_0304, 8'h04, 8'h03, 8'h02, 8'h01};
        tv[3] = '{6, 32'h8001_7F80, 8'h80, 8'h7F, 8'h01, 8'h80};

        rst   = 1'b0;
        ready = 1'b1;
        base  = 32'd0;
        thr   = 35;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        for (int k = 0; k < 4; k++) mem[tv[k].addr] = tv[k].word;

        // Full run with ready held high: sequence, latency and period.
        apply_reset();
        run_until_done(1'b0, 2000);
        for (int e = 0; e < 2; e++) begin
            lat = (e == 0) ? 1 : 3;
            check_run(e, 36);
            if (hs_q[e].size() >= 5 && iss_q[e].size() >= 5) begin
                for (int i = 0; i < 4; i++) begin
                    chk("issue_to_valid", hs_q[e][i].cyc - iss_q[e][i].cyc, lat + 1);
                    chk("record_period", hs_q[e][i+1].cyc - hs_q[e][i].cyc, lat + 4);
                end
            end
            for (int k = 0; k < 4; k++) begin
                if (hs_q[e].size() > tv[k].addr) begin
                    f = hs_q[e][tv[k].addr].flds;
                    chk("vec_index", hs_q[e][tv[k].addr].idx, tv[k].addr);
                    chk("vec_xmin", f[7:0], tv[k].xmin);
                    chk("vec_xmax", f[15:8], tv[k].xmax);
                    chk("vec_ymin", f[23:16], tv[k].ymin);
                    chk("vec_ymax", f[31:24], tv[k].ymax);
                end
            end
`ifdef BOX_FETCH_COUNT_EN
            chk("box_count", cnt_v[e], 32'd36);
            chk("count_mismatch", mism_v[e], 1'b0);
`endif
        end

        // High address bits, random backpressure.
        base = 32'hC3A5_1000;
        thr  = 20;
        apply_reset();
        run_until_done(1'b1, 3000);
        for (int e = 0; e < 2; e++) check_run(e, 21);

        // Stall in PRESENT, then asynchronous reset during WAIT at address 12.
        base  = 32'd0;
        thr   = 35;
        ready = 1'b0;
        apply_reset();
        n = 0;
        @(negedge clk);
        while (!val_v[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("stall_valid_seen", val_v[0], 1'b1);
        snap_f = flds_v[0];
        snap_i = idx_v[0];
        chk("stall_first_box", {snap_i, snap_f}, {32'd0, exp_fields(mem[0])});
        repeat (10) begin
            @(negedge clk);
            chk("stall_valid", val_v[0], 1'b1);
            chk("stall_fields", {flds_v[0], idx_v[0]}, {snap_f, snap_i});
            chk("stall_no_advance", fdr_v[0], 1'b0);
        end
        @(posedge clk); #1;
        ready = 1'b1;
        @(negedge clk);
        chk("accept_cycle_fdr", {val_v[0], fdr_v[0]}, 2'b10);
        @(negedge clk);
        chk("advance_pulse", {val_v[0], fdr_v[0]}, 2'b01);
        n = 0;
        while (!(rd_v[0] && maddr_v[0] == 6'd12) && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("reached_addr12", {rd_v[0], maddr_v[0]}, {1'b1, 6'd12});
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check_zero("async_reset");
        @(posedge clk); #1;
        clear_logs();
        rst = 1'b1;
        run_until_done(1'b1, 3000);
        for (int e = 0; e < 2; e++) check_run(e, 36);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
